// File: rtl/bf_pkg.sv
// Shared types and constant helpers for the receive beamformer.
package bf_pkg;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } cplx_t;

  function automatic int acc_width(input int pw, input int n_ant);
    return pw + $clog2(n_ant);
  endfunction

  function automatic longint round_half(input int ww);
    return longint'(1) <<< (ww - 2);
  endfunction

  // Near-unity real weight in Q1.(ww-1)
  function automatic cplx_t reset_weight(input int ww);
    cplx_t w;
    w.re = 32'((longint'(1) <<< (ww - 1)) - 1);
    w.im = 32'sd0;
    return w;
  endfunction

endpackage

// File: rtl/bf_cmult.sv
// One registered complex multiplier: (x_i + j x_q) * (w_i + j w_q).
module bf_cmult #(
  parameter int DW = 16,
  parameter int WW = 16,
  parameter int PW = 33
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_x_i,
  input  logic signed [DW-1:0] i_x_q,
  input  logic signed [WW-1:0] i_w_i,
  input  logic signed [WW-1:0] i_w_q,
  output logic signed [PW-1:0] o_re,
  output logic signed [PW-1:0] o_im
);

  logic signed [PW-1:0] w_xi, w_xq, w_wi, w_wq;
  logic signed [PW-1:0] r_re_p1, r_im_p1;

  assign w_xi = PW'(i_x_i);
  assign w_xq = PW'(i_x_q);
  assign w_wi = PW'(i_w_i);
  assign w_wq = PW'(i_w_q);

  // S1: product registers
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_re_p1 <= w_xi * w_wi - w_xq * w_wq;
      r_im_p1 <= w_xi * w_wq + w_xq * w_wi;
    end
  end

  assign o_re = r_re_p1;
  assign o_im = r_im_p1;

endmodule

// File: rtl/beamformer_array.sv
// N-antenna receive beamformer with double-buffered complex weights and a 3-stage pipeline.
// Optional BF_SAT_CNT_EN adds a 16-bit saturating count of saturated output beats (sat_cnt).
module beamformer_array
  import bf_pkg::*;
#(
  parameter  int N_ANT = 4,
  parameter  int DW    = 16,
  parameter  int WW    = 16,
  localparam int AW    = $clog2(N_ANT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_ANT*DW-1:0]   in_i,
  input  logic [N_ANT*DW-1:0]   in_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_i,
  output logic [DW-1:0]         out_q,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [WW-1:0]         w_i,
  input  logic [WW-1:0]         w_q,
  input  logic                  w_commit
`ifdef BF_SAT_CNT_EN
  , output logic [15:0]         sat_cnt
`endif
);

  localparam int MW    = (DW > WW) ? DW : WW;
  localparam int PW    = 2 * MW + 1;
  localparam int ACC_W = acc_width(PW, N_ANT);
  localparam int RW    = ACC_W + 1;

  localparam cplx_t                 W_RST   = reset_weight(WW);
  localparam logic signed [WW-1:0]  W_RST_I = W_RST.re[WW-1:0];
  localparam logic signed [WW-1:0]  W_RST_Q = W_RST.im[WW-1:0];
  localparam logic signed [RW-1:0]  RND     = RW'(round_half(WW));
  localparam logic signed [RW-1:0]  SMAX    = RW'((longint'(1) <<< (DW - 1)) - 1);
  localparam logic signed [RW-1:0]  SMIN    = RW'(-(longint'(1) <<< (DW - 1)));

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [RW-1:0] v);
    if (v > SMAX) return SMAX[DW-1:0];
    if (v < SMIN) return SMIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  logic signed [WW-1:0] r_sh_i [N_ANT];
  logic signed [WW-1:0] r_sh_q [N_ANT];
  logic signed [WW-1:0] r_ac_i [N_ANT];
  logic signed [WW-1:0] r_ac_q [N_ANT];
  logic signed [WW-1:0] w_sh_nxt_i [N_ANT];
  logic signed [WW-1:0] w_sh_nxt_q [N_ANT];

  // A commit copies the shadow bank as it will be after this edge's write.
  always_comb begin
    for (int k = 0; k < N_ANT; k++) begin
      w_sh_nxt_i[k] = r_sh_i[k];
      w_sh_nxt_q[k] = r_sh_q[k];
      if (w_we && (w_addr == AW'(k))) begin
        w_sh_nxt_i[k] = w_i;
        w_sh_nxt_q[k] = w_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_ANT; k++) begin
        r_sh_i[k] <= W_RST_I;
        r_sh_q[k] <= W_RST_Q;
        r_ac_i[k] <= W_RST_I;
        r_ac_q[k] <= W_RST_Q;
      end
    end else begin
      for (int k = 0; k < N_ANT; k++) begin
        r_sh_i[k] <= w_sh_nxt_i[k];
        r_sh_q[k] <= w_sh_nxt_q[k];
        if (w_commit) begin
          r_ac_i[k] <= w_sh_nxt_i[k];
          r_ac_q[k] <= w_sh_nxt_q[k];
        end
      end
    end
  end

  // S1: per-antenna complex multiply
  logic signed [PW-1:0] w_p_re [N_ANT];
  logic signed [PW-1:0] w_p_im [N_ANT];

  for (genvar k = 0; k < N_ANT; k++) begin : g_mul
    bf_cmult #(.DW(DW), .WW(WW), .PW(PW)) u_cmult (
      .i_clk (clk),
      .i_en  (w_en),
      .i_x_i (in_i[k*DW +: DW]),
      .i_x_q (in_q[k*DW +: DW]),
      .i_w_i (r_ac_i[k]),
      .i_w_q (r_ac_q[k]),
      .o_re  (w_p_re[k]),
      .o_im  (w_p_im[k])
    );
  end

  // S2: adder tree
  logic signed [ACC_W-1:0] w_sum_re, w_sum_im;
  logic signed [ACC_W-1:0] r_acc_re_p2, r_acc_im_p2;

  always_comb begin
    w_sum_re = '0;
    w_sum_im = '0;
    for (int k = 0; k < N_ANT; k++) begin
      w_sum_re = w_sum_re + ACC_W'(w_p_re[k]);
      w_sum_im = w_sum_im + ACC_W'(w_p_im[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_acc_re_p2 <= w_sum_re;
      r_acc_im_p2 <= w_sum_im;
    end
  end

  // S3: round half-up, rescale, saturate
  logic signed [RW-1:0] w_rnd_re, w_rnd_im, w_shr_re, w_shr_im;
  assign w_rnd_re = RW'(r_acc_re_p2) + RND;
  assign w_rnd_im = RW'(r_acc_im_p2) + RND;
  assign w_shr_re = w_rnd_re >>> (WW - 1);
  assign w_shr_im = w_rnd_im >>> (WW - 1);

  logic r_vld_p1, r_vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else if (w_en) begin
      r_vld_p1  <= in_valid;
      r_vld_p2  <= r_vld_p1;
      out_valid <= r_vld_p2;
      out_i     <= sat_dw(w_shr_re);
      out_q     <= sat_dw(w_shr_im);
    end
  end

`ifdef BF_SAT_CNT_EN
  logic w_sat, r_sat_p3;
  assign w_sat = (w_shr_re > SMAX) || (w_shr_re < SMIN) ||
                 (w_shr_im > SMAX) || (w_shr_im < SMIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_p3 <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      if (w_en) r_sat_p3 <= w_sat;
      if (out_valid && out_ready && r_sat_p3 && (sat_cnt != 16'hFFFF))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_beamformer_array.sv
// Bench for beamformer_array (N_ANT=4, DW=WW=16): vector table, directed corner sequences, random stream vs model.
module tb_beamformer_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_i = '0;
  logic [63:0] in_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_i, out_q;
  logic        w_we = 1'b0;
  logic [1:0]  w_addr = '0;
  logic [15:0] w_i = '0;
  logic [15:0] w_q = '0;
  logic        w_commit = 1'b0;
`ifdef BF_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  beamformer_array #(.N_ANT(4), .DW(16), .WW(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .w_we(w_we), .w_addr(w_addr), .w_i(w_i), .w_q(w_q), .w_commit(w_commit)
`ifdef BF_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] xi;
    logic [63:0] xq;
    logic [15:0] ei;
    logic [15:0] eq;
  } vec_t;

  vec_t vecs [8];

  int n_tests = 0;
  int n_fail  = 0;
  bit last_acc;

  longint m_sh_i [4], m_sh_q [4], m_ac_i [4], m_ac_q [4];
  int     m_sat_cnt;

  logic [15:0] exp_i [$], exp_q [$], obs_i [$], obs_q [$];
  bit          exp_s [$];

  task automatic chk(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_sh_i[k] = 32767; m_sh_q[k] = 0;
      m_ac_i[k] = 32767; m_ac_q[k] = 0;
    end
    m_sat_cnt = 0;
  endfunction

  // y = sum_k w_k * x_k, rounded half-up in Q15, clamped to 16 bits
  function automatic void model(input logic [63:0] xi, input logic [63:0] xq,
                                output logic [15:0] ei, output logic [15:0] eq, output bit sat);
    longint ai, aq, a, b;
    ai = 0; aq = 0;
    for (int k = 0; k < 4; k++) begin
      a = longint'($signed(xi[k*16 +: 16]));
      b = longint'($signed(xq[k*16 +: 16]));
      ai += a * m_ac_i[k] - b * m_ac_q[k];
      aq += a * m_ac_q[k] + b * m_ac_i[k];
    end
    ai = (ai + 16384) >>> 15;
    aq = (aq + 16384) >>> 15;
    sat = (ai > 32767) || (ai < -32768) || (aq > 32767) || (aq < -32768);
    if (ai > 32767) ai = 32767;
    if (ai < -32768) ai = -32768;
    if (aq > 32767) aq = 32767;
    if (aq < -32768) aq = -32768;
    ei = 16'(ai);
    eq = 16'(aq);
  endfunction

  // One clock: book the handshakes seen just before the edge, then advance.
  task automatic cycle();
    logic [15:0] ei, eq, hi, hq;
    bit s, hs, stall;
    #1;
    last_acc = in_valid && in_ready;
    hs       = out_valid && out_ready;
    stall    = out_valid && !out_ready;
    hi = out_i; hq = out_q;
    if (last_acc) begin
      model(in_i, in_q, ei, eq, s);
      exp_i.push_back(ei); exp_q.push_back(eq); exp_s.push_back(s);
    end
    if (hs) begin
      if (exp_i.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        ei = exp_i.pop_front(); eq = exp_q.pop_front(); s = exp_s.pop_front();
        chk("sb_out_i", out_i, ei);
        chk("sb_out_q", out_q, eq);
        if (s && m_sat_cnt < 65535) m_sat_cnt++;
        obs_i.push_back(out_i); obs_q.push_back(out_q);
      end
    end
    if (w_we) begin
      m_sh_i[w_addr] = longint'($signed(w_i));
      m_sh_q[w_addr] = longint'($signed(w_q));
    end
    if (w_commit) begin
      m_ac_i = m_sh_i;
      m_ac_q = m_sh_q;
    end
    @(posedge clk); #1;
    if (stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_out_i", out_i, hi);
      chk("stall_out_q", out_q, hq);
    end
`ifdef BF_SAT_CNT_EN
    chk("sat_cnt", sat_cnt, m_sat_cnt);
`endif
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b1; w_we = 1'b0; w_commit = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20 && exp_i.size() > 0; i++) cycle();
    chk("drain_empty", exp_i.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_in_ready", in_ready, 1);
    exp_i.delete(); exp_q.delete(); exp_s.delete();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
`ifdef BF_SAT_CNT_EN
    chk("rst_sat_cnt", sat_cnt, 0);
`endif
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] wi, input logic [15:0] wq, input logic cm);
    w_we = 1'b1; w_addr = a; w_i = wi; w_q = wq; w_commit = cm;
    cycle();
    w_we = 1'b0; w_commit = 1'b0;
  endtask

  task automatic send(input logic [63:0] xi, input logic [63:0] xq);
    in_i = xi; in_q = xq; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, sent;
    logic [15:0] lane;

    vecs[0] = '{64'h0100_0100_0100_0100, 64'h0, 16'h0400, 16'h0000};
    vecs[1] = '{64'h7FFF_7FFF_7FFF_7FFF, 64'h0, 16'h7FFF, 16'h0000};
    vecs[2] = '{64'h8000_8000_8000_8000, 64'h0, 16'h8000, 16'h0000};
    vecs[3] = '{64'h0, 64'h0100_0100_0100_0100, 16'h0000, 16'h0400};
    vecs[4] = '{64'h0000_0000_0000_0010, 64'h0, 16'h0010, 16'h0000};
    vecs[5] = '{64'h0000_0000_0000_FFFF, 64'h0, 16'hFFFF, 16'h0000};
    vecs[6] = '{64'h0000_0000_0000_0001, 64'h0, 16'h0001, 16'h0000};
    vecs[7] = '{64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 16'h0400, 16'h0400};

    do_reset();

    // Single beats with reset weights: value and 3-cycle latency
    for (int v = 0; v < 8; v++) begin
      out_ready = 1'b1;
      send(vecs[v].xi, vecs[v].xq);
      chk($sformatf("vec%0d_accept", v), last_acc, 1);
      lat = 1;
      while (!out_valid && lat < 10) begin
        cycle();
        lat++;
      end
      chk($sformatf("vec%0d_latency", v), lat, 3);
      chk($sformatf("vec%0d_out_i", v), out_i, vecs[v].ei);
      chk($sformatf("vec%0d_out_q", v), out_q, vecs[v].eq);
      cycle();
    end

    // Ten beats with downstream stalled for cycles 4-7
    obs_i.delete(); obs_q.delete();
    sent = 0;
    for (int c = 0; c < 40 && (sent < 10 || exp_i.size() > 0); c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (sent < 10);
      lane = 16'(sent) * 16'h0123 + 16'h0011;
      in_i = {lane, lane, lane, lane};
      in_q = {~lane, ~lane, ~lane, ~lane};
      if (c == 7) begin
        #1;
        chk("stall_in_ready", in_ready, 0);
      end
      cycle();
      if (last_acc) sent++;
    end
    chk("stall_beats_out", obs_i.size(), 10);
    drain();

    // Shadow writes without commit leave the active bank alone
    wr(2'd0, 16'h0000, 16'h7FFF, 1'b0);
    wr(2'd1, 16'h0000, 16'h0000, 1'b0);
    wr(2'd2, 16'h0000, 16'h0000, 1'b0);
    wr(2'd3, 16'h0000, 16'h0000, 1'b0);
    obs_i.delete(); obs_q.delete();
    send(64'h0100_0100_0100_0100, 64'h0);
    drain();
    chk("precommit_beats", obs_i.size(), 1);
    if (obs_i.size() >= 1) chk("precommit_out_i", obs_i[0], 16'h0400);

    // Commit on the edge accepting beat k: k old weights, k+1 new
    obs_i.delete(); obs_q.delete();
    in_i = 64'h0100_0100_0100_0100; in_q = 64'h0; in_valid = 1'b1; w_commit = 1'b1;
    cycle();
    w_commit = 1'b0;
    cycle();
    drain();
    chk("commit_beats", obs_i.size(), 2);
    if (obs_i.size() >= 2) begin
      chk("commit_k_i", obs_i[0], 16'h0400);
      chk("commit_k_q", obs_q[0], 16'h0000);
      chk("commit_k1_i", obs_i[1], 16'h0000);
      chk("commit_k1_q", obs_q[1], 16'h0100);
    end

    // Pure-imaginary weight on antenna 0
    obs_i.delete(); obs_q.delete();
    send(64'h0000_0000_0000_1000, 64'h0);
    drain();
    if (obs_i.size() >= 1) begin
      chk("jweight_out_i", obs_i[0], 16'h0000);
      chk("jweight_out_q", obs_q[0], 16'h1000);
    end else chk("jweight_beats", obs_i.size(), 1);

    // Write and commit on the same edge
    wr(2'd1, 16'h7FFF, 16'h0000, 1'b1);
    obs_i.delete(); obs_q.delete();
    send(64'h0000_0000_0100_0000, 64'h0);
    drain();
    if (obs_i.size() >= 1) begin
      chk("wrcommit_out_i", obs_i[0], 16'h0100);
      chk("wrcommit_out_q", obs_q[0], 16'h0000);
    end else chk("wrcommit_beats", obs_i.size(), 1);

    // Reset with three beats in flight
    in_i = 64'h0100_0100_0100_0100; in_q = 64'h0; in_valid = 1'b1;
    cycle(); cycle(); cycle();
    in_valid = 1'b0;
    #2;
    do_reset();
    obs_i.delete(); obs_q.delete();
    send(64'h0100_0100_0100_0100, 64'h0);
    drain();
    chk("postrst_beats", obs_i.size(), 1);
    if (obs_i.size() >= 1) begin
      chk("postrst_out_i", obs_i[0], 16'h0400);
      chk("postrst_out_q", obs_q[0], 16'h0000);
    end

    // Random stream with random weight updates and backpressure
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      in_i = {$urandom, $urandom};
      in_q = {$urandom, $urandom};
      if ($urandom % 2 == 0) begin
        in_i = {4{16'($urandom % 4096) - 16'd2048}};
        in_q = {16'($urandom % 512), 16'($urandom % 512), 16'($urandom % 512), 16'($urandom % 512)};
      end
      w_we     = ($urandom % 8) == 0;
      w_addr   = 2'($urandom);
      w_i      = 16'($urandom);
      w_q      = 16'($urandom);
      w_commit = ($urandom % 10) == 0;
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
